fpu_addsub_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision add/subtract unit with a start/done handshake.
- Complements the existing single-cycle adder datapath:
  - handles effective subtraction;
  - handles sign handling and operand swapping;
  - provides the left-shift normalisation path that subtraction needs.
- Sits beside the ALU in the execute stage and stalls the pipeline through `busy`.
- Uses one alignment shift per cycle and one normalisation shift per cycle, so the datapath stays narrow.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_addsub_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential single-precision add/subtract unit.
// Provides the controller state encoding, field widths, the alignment
// saturation limit and the bit positions of the {N,Z,C,V} flag vector.
package fpu_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 23;
    localparam int unsigned EXP_MAX   = 255;
    // Shifting a 24-bit mantissa 25 places clears it, so longer shifts add nothing.
    localparam int unsigned ALIGN_SAT = 25;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        OP,
        NORM
    } state_t;

endpackage

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with start/done handshake.
// One alignment shift and one normalisation shift per cycle; truncating rounding.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      launch an operation (sampled only while idle)
//   FPUControl 0 = A+B, 1 = A-B
//   A, B       IEEE single operands (exp 0 flushes to zero, exp 255 treated as normal)
//   busy       high while an operation is in flight
//   done       one-cycle pulse when Result/ALUFlags are updated
//   Result     packed result, held between operations
//   ALUFlags   {N,Z,C,V}: sign, zero, inexact, overflow
module fpu_addsub_seq #(
    parameter int unsigned EXP_W = fpu_pkg::EXP_W,
    parameter int unsigned MAN_W = fpu_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   FPUControl,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   Result,
    output logic [3:0]             ALUFlags
);
    import fpu_pkg::*;

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned MW = MAN_W + 1;   // mantissa with hidden bit
    localparam int unsigned SW = MAN_W + 2;   // sum with carry bit
    localparam int unsigned CW = $clog2(ALIGN_SAT + 1);

    localparam logic [EXP_W-1:0] SAT_E      = EXP_W'(ALIGN_SAT);
    localparam logic [CW-1:0]    CNT_SAT    = CW'(ALIGN_SAT);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [EXP_W:0]   EXPR_ONE   = (EXP_W + 1)'(1);
    // A carry out of this exponent (or above) lands on the reserved code.
    localparam logic [EXP_W:0]   EXPR_OVF_M = (EXP_W + 1)'(EXP_MAX - 1);

    // Operand unpack and magnitude ordering
    logic             sa, sb_eff;
    logic [EXP_W-1:0] ea, eb, el, es, diff;
    logic [MW-1:0]    ma, mb, ml, ms;
    logic             a_ge_b;
    logic [CW-1:0]    dsat;

    always_comb begin
        sa     = A[W-1];
        sb_eff = B[W-1] ^ FPUControl;
        ea     = A[MAN_W +: EXP_W];
        eb     = B[MAN_W +: EXP_W];
        ma     = (ea == '0) ? '0 : {1'b1, A[MAN_W-1:0]};
        mb     = (eb == '0) ? '0 : {1'b1, B[MAN_W-1:0]};
        a_ge_b = ({ea, ma} >= {eb, mb});
        el     = a_ge_b ? ea : eb;
        es     = a_ge_b ? eb : ea;
        ml     = a_ge_b ? ma : mb;
        ms     = a_ge_b ? mb : ma;
        diff   = el - es;
        dsat   = (diff > SAT_E) ? CNT_SAT : diff[CW-1:0];
    end

    // State
    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic            sub_q, sub_d;
    logic [MW-1:0]   mant_l_q, mant_l_d;
    logic [MW-1:0]   mant_s_q, mant_s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EXP_W:0]  expr_q, expr_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            sticky_q, sticky_d;
    logic [W-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;
    logic            done_q, done_d;

    logic            fin;
    logic            fin_ovf;
    logic [W-1:0]    fin_res;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        mant_l_d = mant_l_q;
        mant_s_d = mant_s_q;
        cnt_d    = cnt_q;
        expr_d   = expr_q;
        sum_d    = sum_q;
        sticky_d = sticky_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        fin      = 1'b0;
        fin_ovf  = 1'b0;
        fin_res  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = a_ge_b ? sa : sb_eff;
                    sub_d    = sa ^ sb_eff;
                    mant_l_d = ml;
                    mant_s_d = ms;
                    expr_d   = {1'b0, el};
                    cnt_d    = dsat;
                    sticky_d = 1'b0;
                    state_d  = (dsat != '0) ? ALIGN : OP;
                end
            end
            ALIGN: begin
                mant_s_d = mant_s_q >> 1;
                sticky_d = sticky_q | mant_s_q[0];
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = OP;
                end
            end
            OP: begin
                // Ordering guarantees L >= S, so the difference never goes negative.
                sum_d   = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                                : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
                state_d = NORM;
            end
            NORM: begin
                if (sum_q == '0) begin
                    fin = 1'b1;
                end else if (sum_q[SW-1]) begin
                    sum_d    = sum_q >> 1;
                    sticky_d = sticky_q | sum_q[0];
                    expr_d   = expr_q + EXPR_ONE;
                    if (expr_q >= EXPR_OVF_M) begin
                        fin     = 1'b1;
                        fin_ovf = 1'b1;
                        fin_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end
                end else if (!sum_q[SW-2]) begin
                    sum_d  = sum_q << 1;
                    expr_d = expr_q - EXPR_ONE;
                    // Exponent hitting zero flushes the result to +0.
                    if (expr_q <= EXPR_ONE) begin
                        fin = 1'b1;
                    end
                end else begin
                    fin     = 1'b1;
                    fin_res = {sign_q, expr_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d          = IDLE;
            done_d           = 1'b1;
            result_d         = fin_res;
            flags_d[FLAG_N]  = fin_res[W-1];
            flags_d[FLAG_Z]  = (fin_res[W-2:0] == '0);
            flags_d[FLAG_C]  = sticky_d;
            flags_d[FLAG_V]  = fin_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            mant_l_q <= '0;
            mant_s_q <= '0;
            cnt_q    <= '0;
            expr_q   <= '0;
            sum_q    <= '0;
            sticky_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            mant_l_q <= mant_l_d;
            mant_s_q <= mant_s_d;
            cnt_q    <= cnt_d;
            expr_q   <= expr_d;
            sum_q    <= sum_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign Result   = result_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Self-checking bench for fpu_addsub_seq: directed vectors plus randomized
// operands compared against an arithmetic reference model.
module tb_fpu_addsub_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        FPUControl;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;

    int checks = 0;
    int errors = 0;

    fpu_addsub_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .FPUControl (FPUControl),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value-level add/sub with the unit's flush, truncation and cycle rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        int     ea, eb, el, es, d, k, nc;
        longint ma, mb, ml, ms, sum;
        bit     sa, sb, sgn, stk, ovf;
        sa = a[31];
        sb = b[31] ^ op;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
        if (ea > eb || (ea == eb && ma >= mb)) begin
            el = ea; ml = ma; es = eb; ms = mb; sgn = sa;
        end else begin
            el = eb; ml = mb; es = ea; ms = ma; sgn = sb;
        end
        d = el - es;
        if (d > 25) d = 25;
        stk = (ms % (longint'(1) << d)) != 0;
        ms  = ms >> d;
        sum = (sa != sb) ? ml - ms : ml + ms;
        ovf = 0;
        if (sum == 0) begin
            r  = 32'h0;
            nc = 1;
        end else if (sum >= (longint'(1) << 24)) begin
            stk = stk | ((sum % 2) != 0);
            if (el + 1 >= 255) begin
                r   = {sgn, 8'hFF, 23'h0};
                ovf = 1;
                nc  = 1;
            end else begin
                r  = {sgn, 8'(el + 1), 23'(sum >> 1)};
                nc = 2;
            end
        end else begin
            k = 0;
            while ((sum << k) < (longint'(1) << 23)) k++;
            if (el - k <= 0) begin
                r  = 32'h0;
                nc = el;
            end else begin
                r  = {sgn, 8'(el - k), 23'(sum << k)};
                nc = k + 1;
            end
        end
        f   = {r[31], (r[30:0] == 31'h0), stk, ovf};
        lat = d + 1 + nc;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd254;
            2:       e = 8'd255;
            3:       e = 8'd1;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Second operand biased toward near-equal magnitudes to exercise cancellation.
    function automatic logic [31:0] gen_b(input logic [31:0] a);
        logic [7:0] e;
        int sel, dl;
        sel = $urandom_range(0, 3);
        e   = a[30:23];
        dl  = $urandom_range(0, 4);
        case (sel)
            0: return rnd_fp();
            1: begin
                e = (e > 8'd4) ? e - 8'(dl) : e + 8'(dl);
                return {1'($urandom), e, 23'($urandom)};
            end
            2: return {1'($urandom), e, a[22:0] ^ 23'($urandom_range(0, 255))};
            default: return {1'($urandom), a[30:0]};
        endcase
    endfunction

    // Launches one operation (start presented at #1 after an edge) and checks it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] er, input logic [3:0] ef,
                          input int elat);
        int lat;
        A = a; B = b; FPUControl = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "/busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/lat"}, 32'(lat), 32'(elat));
        check({tag, "/result"}, Result, er);
        check({tag, "/flags"}, 32'(ALUFlags), 32'(ef));
        check({tag, "/busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic [3:0]  ef;
        logic        rop;
        int          elat, lat;

        reset_n = 1'b0; start = 1'b0; FPUControl = 1'b0; A = '0; B = '0;
        #12;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/result", Result, 32'h0);
        check("rst/flags", 32'(ALUFlags), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("sub3m1",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 3);
        run_op("add1p1",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 3);
        run_op("sub1m1",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0100, 2);
        run_op("sub1m3",  32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b1000, 3);
        run_op("bigm1",   32'h4B000000, 32'h3F800000, 1'b1, 32'h4AFFFFFE, 4'b0000, 26);
        run_op("inexact", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, 26);
        run_op("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0001, 2);
        run_op("uflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0100, 2);
        run_op("negneg",  32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 4'b1000, 3);
        run_op("subneg",  32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000, 3);
        run_op("zeroadd", 32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 4'b0000, 27);
        run_op("denorm",  32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0100, 2);

        // A second start while busy must not disturb the running operation.
        A = 32'h4B000000; B = 32'h3F800000; FPUControl = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        A = 32'h3F800000; B = 32'h3F800000; FPUControl = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore/lat", 32'(lat), 32'd26);
        check("ignore/result", Result, 32'h4AFFFFFE);
        check("ignore/flags", 32'(ALUFlags), 32'h0);

        // Reset mid-operation aborts with no done pulse and clears outputs.
        A = 32'h4B000000; B = 32'h3F800000; FPUControl = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort/done1", 32'(done), 32'd0);
        @(posedge clk); #1;
        start = 1'b1;
        check("abort/busy3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("abort/done4", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/result", Result, 32'h0);
        check("abort/flags", 32'(ALUFlags), 32'h0);
        @(posedge clk); #1;
        check("abort/done_hold", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 3);

        for (int i = 0; i < 150; i++) begin
            ra  = rnd_fp();
            rb  = gen_b(ra);
            rop = 1'($urandom);
            model(ra, rb, rop, er, ef, elat);
            run_op($sformatf("rnd%0d", i), ra, rb, rop, er, ef, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
